// File: rtl/controlador_es_pkg.sv
// Shared definitions for the IN/OUT controller: FSM state encoding and default debounce time.
package controlador_es_pkg;

  typedef enum logic [2:0] {
    OCIOSO     = 3'd0,
    ESPERA_IN  = 3'd1,
    ESPERA_OUT = 3'd2,
    SOLTA      = 3'd3,
    ARMADO     = 3'd4
  } estado_t;

  // 10 ms at 50 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/controlador_es_filtro_botao.sv
// Button conditioner: 2-FF synchronizer, debounce counter, clean level and press pulse.
module filtro_botao #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic clock_fpga_i,
  input  logic reset_n_i,
  input  logic botao_i,
  output logic nivel_o,
  output logic aperto_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync1_q, sync2_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 nivel_q, nivel_d;
  logic                 aperto_q, aperto_d;

  // Any cycle where the synchronized level agrees with the clean level restarts the count.
  always_comb begin
    cnt_d    = '0;
    nivel_d  = nivel_q;
    aperto_d = 1'b0;
    if (sync2_q != nivel_q) begin
      if (cnt_q == CNT_MAX) begin
        nivel_d  = sync2_q;
        aperto_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock_fpga_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      nivel_q  <= 1'b1;
      aperto_q <= 1'b0;
    end else begin
      sync1_q  <= botao_i;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      nivel_q  <= nivel_d;
      aperto_q <= aperto_d;
    end
  end

  assign nivel_o  = nivel_q;
  assign aperto_o = aperto_q;

endmodule

// File: rtl/controlador_es.sv
// Freezes the processor clock on IN/OUT instructions until the user presses the board button.
module controlador_es
  import controlador_es_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_WIDTH       = 20,
  parameter int SW_WIDTH        = 8,
  parameter int IMM_WIDTH       = 14,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                  clock_fpga,
  input  logic                  reset_n,
  input  logic                  botao,
  input  logic                  req_congela_in,
  input  logic                  req_congela_out,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [SW_WIDTH-1:0]   switches,
  input  logic [DATA_WIDTH-1:0] dado_saida,
  output logic                  congela,
  output logic [IMM_WIDTH-1:0]  valor_in,
  output logic [DATA_WIDTH-1:0] valor_out,
  output logic                  aguardando
);

  estado_t               estado_q, estado_d;
  logic [DATA_WIDTH-1:0] pc_latch_q, pc_latch_d;
  logic [IMM_WIDTH-1:0]  valor_in_q, valor_in_d;
  logic [DATA_WIDTH-1:0] valor_out_q, valor_out_d;
  logic                  congela_q, congela_d;
  logic                  aguardando_q, aguardando_d;
  logic                  nivel, aperto;

  filtro_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_filtro (
    .clock_fpga_i(clock_fpga),
    .reset_n_i   (reset_n),
    .botao_i     (botao),
    .nivel_o     (nivel),
    .aperto_o    (aperto)
  );

  // ARMADO waits for the PC to move so the same instruction cannot freeze twice.
  always_comb begin
    estado_d    = estado_q;
    pc_latch_d  = pc_latch_q;
    valor_in_d  = valor_in_q;
    valor_out_d = valor_out_q;
    case (estado_q)
      OCIOSO: begin
        if (req_congela_in) begin
          estado_d   = ESPERA_IN;
          pc_latch_d = pc;
        end else if (req_congela_out) begin
          estado_d    = ESPERA_OUT;
          pc_latch_d  = pc;
          valor_out_d = dado_saida;
        end
      end
      ESPERA_IN: begin
        if (aperto) begin
          valor_in_d = IMM_WIDTH'(switches);
          estado_d   = SOLTA;
        end
      end
      ESPERA_OUT: if (aperto) estado_d = SOLTA;
      SOLTA:      if (nivel) estado_d = ARMADO;
      ARMADO:     if (pc != pc_latch_q) estado_d = OCIOSO;
      default:    estado_d = OCIOSO;
    endcase
    congela_d    = (estado_d == ESPERA_IN) || (estado_d == ESPERA_OUT) || (estado_d == SOLTA);
    aguardando_d = (estado_d == ESPERA_IN) || (estado_d == ESPERA_OUT);
  end

  always_ff @(posedge clock_fpga or negedge reset_n) begin
    if (!reset_n) begin
      estado_q     <= OCIOSO;
      pc_latch_q   <= '0;
      valor_in_q   <= '0;
      valor_out_q  <= '0;
      congela_q    <= 1'b0;
      aguardando_q <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      pc_latch_q   <= pc_latch_d;
      valor_in_q   <= valor_in_d;
      valor_out_q  <= valor_out_d;
      congela_q    <= congela_d;
      aguardando_q <= aguardando_d;
    end
  end

  assign congela    = congela_q;
  assign valor_in   = valor_in_q;
  assign valor_out  = valor_out_q;
  assign aguardando = aguardando_q;

endmodule
